// File: rtl/event_meter_pkg.sv
// Purpose: shared FSM state encoding and counter constants for event_interval_meter.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package event_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // Widest counter supported; instances slice the low WIDTH bits.
  localparam int unsigned CNT_MAX_WIDTH = 64;
  localparam logic [CNT_MAX_WIDTH-1:0] CNT_ALL_ONES = '1;

endpackage

// File: rtl/sync_edge_detect.sv
// Purpose: multi-flop synchroniser for an asynchronous strobe plus registered rising-edge detector.
// Latency: edge_pulse asserts SYNC_STAGES+1 cycles after async_in rises; one cycle wide.
// Backpressure: none; the source must hold each level for at least 2 clk cycles.
//
// Ports: clk, reset (sync, active-high), async_in (raw strobe), edge_pulse (one-cycle rising-edge flag).
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_chain <= '0;
      sync_d     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
      sync_d     <= sync_chain[SYNC_STAGES-1];
      edge_pulse <= sync_chain[SYNC_STAGES-1] & ~sync_d;
    end
  end

endmodule

// File: rtl/event_interval_meter.sv
// Purpose: measures clk cycles between successive rising edges of an async event, with a missing-event timeout.
// Latency: period_valid/timeout are registered pulses; the internal edge lags event_in by SYNC_STAGES+1 cycles.
// Backpressure: none; results are pulses and the last period is held in period_cycles.
//
// Ports:
//   clk, reset (sync, active-high), enable (low forces IDLE), event_in (async strobe)
//   clock_frequency [Hz], timeout_seconds (0 disables timeout)
//   period_cycles (last interval), period_valid (pulse), timeout (pulse),
//   saturated (sticky counter clip), measuring (high in MEASURE)
// WIDTH may be at most 64.
module event_interval_meter
  import event_meter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             event_in,
  input  logic [WIDTH-1:0] clock_frequency,
  input  logic [WIDTH-1:0] timeout_seconds,
  output logic [WIDTH-1:0] period_cycles,
  output logic             period_valid,
  output logic             timeout,
  output logic             saturated,
  output logic             measuring
);

  localparam logic [WIDTH-1:0] ALL_ONES = CNT_ALL_ONES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] counter, counter_nxt;
  logic [WIDTH-1:0] counter_inc;
  logic [WIDTH-1:0] period_nxt;
  logic             valid_nxt, timeout_nxt, sat_nxt;
  logic [WIDTH-1:0] limit;
  logic             edge_det;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .async_in  (event_in),
    .edge_pulse(edge_det)
  );

  // Only the low WIDTH bits of the product are used; overflow wraps by design.
  assign limit       = clock_frequency * timeout_seconds;
  assign counter_inc = counter + CNT_ONE;
  assign measuring   = (state == ST_MEASURE);

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    period_nxt  = period_cycles;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    sat_nxt     = saturated;

    if (!enable) begin
      state_nxt   = ST_IDLE;
      counter_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          counter_nxt = '0;
          state_nxt   = ST_ARM;
        end
        ST_ARM: begin
          // First edge only starts the interval; nothing to report yet.
          if (edge_det) begin
            counter_nxt = CNT_ONE;
            state_nxt   = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // Edge is checked first so it wins over a coincident timeout.
          if (edge_det) begin
            period_nxt  = counter;
            valid_nxt   = 1'b1;
            counter_nxt = CNT_ONE;
          end else if ((limit != '0) && (counter == limit)) begin
            timeout_nxt = 1'b1;
            counter_nxt = '0;
            state_nxt   = ST_ARM;
          end else if (counter != ALL_ONES) begin
            counter_nxt = counter_inc;
            if (counter_inc == ALL_ONES) begin
              sat_nxt = 1'b1;
            end
          end
        end
        default: begin
          state_nxt   = ST_IDLE;
          counter_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      counter       <= '0;
      period_cycles <= '0;
      period_valid  <= 1'b0;
      timeout       <= 1'b0;
      saturated     <= 1'b0;
    end else begin
      state         <= state_nxt;
      counter       <= counter_nxt;
      period_cycles <= period_nxt;
      period_valid  <= valid_nxt;
      timeout       <= timeout_nxt;
      saturated     <= sat_nxt;
    end
  end

endmodule
